// File: rtl/rr_encoder_16_to_4.sv
// rr_encoder_16_to_4
//   Turns a vector of level-sensitive request lines into one granted index.
//   If several lines are active, a round-robin pointer picks the winner. The
//   offer goes to the consumer over a valid/ready handshake. The granted
//   requester gets a one-hot acknowledge in the cycle the offer is accepted.
//
// Parameters
//   AW        index width; the request vector has N = 2**AW lines
//   START_PTR round-robin pointer value after reset (0..N-1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   Req        request lines, bit i = requester i
//   Out_Ready  consumer accepts the current offer
//   Out_Valid  offer valid; Out_Add holds the granted index
//   Out_Add    granted requester index
//   Ack        one-hot acknowledge, only set in the handshake cycle
module rr_encoder_16_to_4 #(
  parameter int unsigned AW        = 4,
  parameter int unsigned START_PTR = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2**AW-1:0]   Req,
  input  logic               Out_Ready,
  output logic               Out_Valid,
  output logic [AW-1:0]      Out_Add,
  output logic [2**AW-1:0]   Ack
);

  localparam int unsigned N = 2 ** AW;

  typedef enum logic [0:0] {
    StIdle,
    StOffer
  } state_e;

  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic          valid_q;
  logic [AW-1:0] add_q;

  logic [AW-1:0] cand;
  logic [AW-1:0] sel_idx;
  logic          sel_found;
  logic          handshake;

  // Scan upward from the pointer. The AW-bit sum wraps modulo N, so
  // N-1 is followed by 0.
  always_comb begin
    cand      = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = ptr_q + AW'(i);
      if (!sel_found && Req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign handshake = valid_q & Out_Ready;

  always_comb begin
    Ack = '0;
    if (handshake) begin
      Ack[add_q] = 1'b1;
    end
  end

  assign Out_Valid = valid_q;
  assign Out_Add   = add_q;

  // The offer is committed once it leaves IDLE. Req is not sampled again
  // until the offer is accepted, so a request cannot withdraw its grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= AW'(START_PTR);
      valid_q <= 1'b0;
      add_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sel_found) begin
            add_q   <= sel_idx;
            valid_q <= 1'b1;
            state_q <= StOffer;
          end
        end
        StOffer: begin
          if (Out_Ready) begin
            ptr_q   <= add_q + 1'b1;
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_encoder_16_to_4.sv
// Scoreboard bench for rr_encoder_16_to_4. A behavioural model predicts each
// offer and pushes the expected index into a queue. A monitor on the falling
// edge pops that queue on every handshake and compares the DUT against it.
module tb_rr_encoder_16_to_4;

  localparam int AW        = 4;
  localparam int N         = 16;
  localparam int START_PTR = 0;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          out_ready;
  logic          out_valid;
  logic [AW-1:0] out_add;
  logic [N-1:0]  ack;

  rr_encoder_16_to_4 #(
    .AW       (AW),
    .START_PTR(START_PTR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Req      (req),
    .Out_Ready(out_ready),
    .Out_Valid(out_valid),
    .Out_Add  (out_add),
    .Ack      (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int exp_q[$];
  int grant_log[$];
  int grant_cyc[$];

  bit           auto_drop = 1'b0;
  logic [N-1:0] ack_seen  = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  // Reference model: the first active request at or after ptr, with wrap.
  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  bit m_valid;
  int m_add;
  int m_ptr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_add   = 0;
      m_ptr   = START_PTR;
      exp_q.delete();
    end else if (!m_valid) begin
      if (req != '0) begin
        m_add   = rr_pick(req, m_ptr);
        m_valid = 1'b1;
        exp_q.push_back(m_add);
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
      m_ptr   = (m_add + 1) % N;
    end
  end

  // Monitor: checks every cycle and scores each handshake against the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      int e;
      ack_seen = ack;
      check("valid_vs_model", 32'(out_valid), 32'(m_valid));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail("handshake_without_expected_offer");
        end else begin
          e = exp_q.pop_front();
          check("grant_add", 32'(out_add), 32'(e));
          check("grant_ack", 32'(ack), 32'(1) << e);
          grant_log.push_back(int'(out_add));
          grant_cyc.push_back(cyc);
        end
      end else begin
        check("ack_idle_zero", 32'(ack), 32'd0);
      end
      if (m_valid) check("offer_add_stable", 32'(out_add), 32'(m_add));
    end
  end

  // Advance one cycle. Inputs change 2 time units after the edge; optionally
  // a requester drops its line after being acknowledged.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (auto_drop) req = req & ~ack_seen;
    end
  endtask

  task automatic wait_grants(input int target, input int budget, input string name);
    int k = 0;
    while (grant_log.size() < target && k < budget) begin
      tick(1);
      k++;
    end
    if (grant_log.size() < target) fail(name);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k = 0;
    while (!out_valid && k < budget) begin
      tick(1);
      k++;
    end
    if (!out_valid) fail(name);
  endtask

  task automatic expect_grant(input int pos, input int val, input string name);
    if (grant_log.size() > pos) check(name, 32'(grant_log[pos]), 32'(val));
    else fail(name);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req   = '0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    tick(2);
    rst_n = 1'b1;

    // 1: idle after reset
    tick(10);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_add", 32'(out_add), 32'd0);
    check("reset_ack", 32'(ack), 32'd0);

    // 2: single request, then the pointer sits at 6
    auto_drop = 1'b1;
    out_ready = 1'b1;
    b = grant_log.size();
    req = 16'h0020;
    wait_grants(b + 1, 8, "t2_timeout");
    expect_grant(b, 5, "t2_grant5");
    tick(1);
    check("t2_valid_drops", 32'(out_valid), 32'd0);
    req = 16'h0041;
    wait_grants(b + 3, 12, "t2b_timeout");
    expect_grant(b + 1, 6, "t2_ptr6_first");
    expect_grant(b + 2, 0, "t2_wrap_second");

    // 3: four requesters from pointer 0, two cycles apart, pointer wraps to 0
    do_reset();
    b = grant_log.size();
    req = 16'h8421;
    wait_grants(b + 4, 20, "t3_timeout");
    expect_grant(b, 0, "t3_g0");
    expect_grant(b + 1, 5, "t3_g5");
    expect_grant(b + 2, 10, "t3_g10");
    expect_grant(b + 3, 15, "t3_g15");
    if (grant_cyc.size() >= b + 4) begin
      for (int i = 0; i < 3; i++) begin
        check("t3_spacing", 32'(grant_cyc[b+i+1] - grant_cyc[b+i]), 32'd2);
      end
    end
    req = 16'h0003;
    wait_grants(b + 5, 8, "t3_wrap_timeout");
    expect_grant(b + 4, 0, "t3_wrap_to_0");
    wait_grants(b + 6, 8, "t3_tail_timeout");

    // 4: backpressure holds the offer; other Req changes are ignored
    out_ready = 1'b0;
    b = grant_log.size();
    req = 16'h0004;
    wait_valid(6, "t4_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      if (i == 2) req = 16'h0008;
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_add", 32'(out_add), 32'd2);
      check("t4_hold_ack", 32'(ack), 32'd0);
      tick(1);
    end
    out_ready = 1'b1;
    wait_grants(b + 2, 10, "t4_timeout");
    expect_grant(b, 2, "t4_grant2");
    expect_grant(b + 1, 3, "t4_grant3");

    // 5: fairness after a grant of 13
    b = grant_log.size();
    req = 16'h2000;
    wait_grants(b + 1, 8, "t5a_timeout");
    tick(1);
    req = 16'h4003;
    wait_grants(b + 4, 16, "t5_timeout");
    expect_grant(b, 13, "t5_g13");
    expect_grant(b + 1, 14, "t5_g14");
    expect_grant(b + 2, 0, "t5_g0");
    expect_grant(b + 3, 1, "t5_g1");

    // 6: reset during an offer; pointer returns to START_PTR
    out_ready = 1'b0;
    req = 16'h0010;
    wait_valid(6, "t6_valid_timeout");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(out_valid), 32'd0);
    check("t6_async_ack", 32'(ack), 32'd0);
    out_ready = 1'b1;
    req = 16'h8002;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    b = grant_log.size();
    wait_valid(2, "t6_revalid_timeout");
    check("t6_add_after_reset", 32'(out_add), 32'd1);
    wait_grants(b + 2, 10, "t6_timeout");
    expect_grant(b, 1, "t6_g1");
    expect_grant(b + 1, 15, "t6_g15");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      auto_drop = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) == 0) req = N'($urandom);
      else if ($urandom_range(0, 2) == 0) req = req | (N'(1) << $urandom_range(0, N - 1));
      out_ready = ($urandom_range(0, 2) != 0);
      tick(1);
    end
    req = '0;
    out_ready = 1'b1;
    tick(4);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
